// File: rtl/wb_unit_if.sv
// wb_unit_if: bundle of the writeback stage's bus signals.
//   MEM -> WB   : mem_valid/mem_ready handshake plus the retiring instruction's fields
//   DBUS -> WB  : dresp_valid/dresp_data load response
//   WB -> GPR   : wr_en/index_rd/data_rd write port, instr_valid/commit_pc commit
//   WB -> hazard: wb_pend/wb_pend_rd, wb_err
// The slave modport is the writeback unit's view; master is the environment's.
interface wb_unit_if #(parameter int XLEN = 64);
  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_pc;
  logic            mem_wen;
  logic [4:0]      mem_rd;
  logic            mem_is_load;
  logic [2:0]      mem_funct3;
  logic [2:0]      mem_addr_lo;
  logic [XLEN-1:0] mem_result;
  logic            dresp_valid;
  logic [XLEN-1:0] dresp_data;
  logic            wr_en;
  logic [4:0]      index_rd;
  logic [XLEN-1:0] data_rd;
  logic            instr_valid;
  logic [XLEN-1:0] commit_pc;
  logic            wb_pend;
  logic [4:0]      wb_pend_rd;
  logic            wb_err;

  modport slave (
    input  mem_valid, mem_pc, mem_wen, mem_rd, mem_is_load, mem_funct3,
           mem_addr_lo, mem_result, dresp_valid, dresp_data,
    output mem_ready, wr_en, index_rd, data_rd, instr_valid, commit_pc,
           wb_pend, wb_pend_rd, wb_err
  );

  modport master (
    output mem_valid, mem_pc, mem_wen, mem_rd, mem_is_load, mem_funct3,
           mem_addr_lo, mem_result, dresp_valid, dresp_data,
    input  mem_ready, wr_en, index_rd, data_rd, instr_valid, commit_pc,
           wb_pend, wb_pend_rd, wb_err
  );
endinterface

// File: rtl/wb_unit.sv
// wb_unit: writeback stage. Accepts one retiring instruction at a time from MEM,
// waits for the load response when needed, and commits it to the GPR write port
// for exactly one cycle.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - wb_unit_if.slave: MEM handshake, load response, GPR write / commit,
//          hazard (pending rd) and sticky error outputs
module wb_unit #(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       rstn,
  wb_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_pc, r_data;
  logic            r_wen;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3, r_addr_lo;
  logic            r_err;
  // Last committed values: the write-port fields hold these outside COMMIT.
  logic [XLEN-1:0] r_last_pc, r_last_data;
  logic [4:0]      r_last_rd;

  logic            w_ready, w_accept, w_commit, w_pend;
  logic [XLEN-1:0] w_shift, w_ext;
  logic            w_bad_f3;

  assign w_ready  = (r_state != S_LOAD);
  assign w_accept = bus.mem_valid && w_ready;
  assign w_commit = (r_state == S_COMMIT);
  assign w_pend   = (r_state != S_IDLE) && r_wen && (r_rd != 5'd0);

  // Byte-select the addressed lane, then extend per the load encoding.
  always_comb begin
    w_shift  = bus.dresp_data >> {r_addr_lo, 3'b000};
    w_ext    = '0;
    w_bad_f3 = 1'b0;
    case (r_funct3)
      3'b000: w_ext = {{(XLEN-8){w_shift[7]}},   w_shift[7:0]};
      3'b001: w_ext = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      3'b010: w_ext = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
      3'b011: w_ext = w_shift;
      3'b100: w_ext = {{(XLEN-8){1'b0}},  w_shift[7:0]};
      3'b101: w_ext = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      3'b110: w_ext = {{(XLEN-32){1'b0}}, w_shift[31:0]};
      default: begin
        w_ext    = '0;
        w_bad_f3 = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD: if (bus.dresp_valid) w_next = S_COMMIT;
      default: begin
        // IDLE and COMMIT both accept; COMMIT falls back to IDLE when nothing arrives.
        if (w_accept) w_next = bus.mem_is_load ? S_LOAD : S_COMMIT;
        else          w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc        <= '0;
      r_data      <= '0;
      r_wen       <= 1'b0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_err       <= 1'b0;
      r_last_pc   <= '0;
      r_last_data <= '0;
      r_last_rd   <= '0;
    end else begin
      if (w_commit) begin
        r_last_pc   <= r_pc;
        r_last_data <= r_data;
        r_last_rd   <= r_rd;
      end
      if (w_accept) begin
        r_pc      <= bus.mem_pc;
        r_wen     <= bus.mem_wen;
        r_rd      <= bus.mem_rd;
        r_funct3  <= bus.mem_funct3;
        r_addr_lo <= bus.mem_addr_lo;
        r_data    <= bus.mem_result;
      end else if (r_state == S_LOAD && bus.dresp_valid) begin
        r_data <= w_ext;
        if (w_bad_f3) r_err <= 1'b1;
      end
      // A response with no load outstanding is a protocol error and is dropped.
      if (r_state != S_LOAD && bus.dresp_valid) r_err <= 1'b1;
    end
  end

  assign bus.mem_ready   = w_ready;
  assign bus.instr_valid = w_commit;
  assign bus.wr_en       = w_commit && r_wen && (r_rd != 5'd0);
  assign bus.index_rd    = w_commit ? r_rd   : r_last_rd;
  assign bus.data_rd     = w_commit ? r_data : r_last_data;
  assign bus.commit_pc   = w_commit ? r_pc   : r_last_pc;
  assign bus.wb_pend     = w_pend;
  assign bus.wb_pend_rd  = w_pend ? r_rd : 5'd0;
  assign bus.wb_err      = r_err;

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback stage of the 5-stage pipeline: the writer side of the GPR file's write port.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- For loads, waits for the data-bus response, then byte-selects and sign- or zero-extends the data.
- Drives the regfile write port (wr_en / index_rd / data_rd / instr_valid) for exactly one cycle per retired instruction, and exports a pending-rd indication for hazard detection.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- mem_valid  input  1  MEM stage presents a retiring instruction
- mem_ready  output  1  wb_unit can accept this cycle
- mem_pc  input  64  PC of the presented instruction
- mem_wen  input  1  instruction writes rd
- mem_rd  input  5  destination register index
- mem_is_load  input  1  instruction is a load; result comes from dresp_data
- mem_funct3  input  3  load width/sign encoding (RV64I)
- mem_addr_lo  input  3  load address bits [2:0]
- mem_result  input  64  ALU/CSR/link result (non-load)
- dresp_valid  input  1  load data response, single-cycle pulse
- dresp_data  input  64  naturally aligned doubleword containing the load data
- wr_en  output  1  regfile write enable
- index_rd  output  5  regfile write index
- data_rd  output  64  regfile write data
- instr_valid  output  1  commit pulse, one cycle per retired instruction
- commit_pc  output  64  PC of the committing instruction
- wb_pend  output  1  an instruction with a pending rd write is held
- wb_pend_rd  output  5  rd of that instruction
- wb_err  output  1  sticky protocol/encoding error flag

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; all outputs and held registers 0.
  - Reset mid-load discards the held load; a later dresp_valid is then unexpected and sets wb_err.
- States:
  - IDLE: nothing held.
  - LOAD: holding a load, awaiting dresp_valid.
  - COMMIT: holding a completed result; outputs are driven this cycle.
- mem_ready = (state != LOAD). It is combinational from state only and never depends on mem_valid.
- Accept = mem_valid && mem_ready. On accept, latch pc, wen, rd, funct3, addr_lo and result.
  - Non-load: next state COMMIT; data = mem_result.
  - Load: next state LOAD.
- LOAD:
  - On dresp_valid: data = extend(dresp_data >> (8*addr_lo)); next state COMMIT.
  - Without dresp_valid: stay in LOAD indefinitely.
- COMMIT (exactly one cycle per instruction):
  - instr_valid=1, commit_pc=held pc.
  - wr_en = held wen && held rd != 0.
  - index_rd = held rd, data_rd = held data.
  - A simultaneous accept goes to COMMIT or LOAD as above; otherwise next state IDLE. This gives throughput 1 instr/cycle for back-to-back non-loads.
- Outside COMMIT, instr_valid=0 and wr_en=0. index_rd, data_rd and commit_pc hold their last values.
- Latency:
  - Non-load: commit in the cycle after accept.
  - Load: commit in the cycle after dresp_valid. dresp_valid can arrive no earlier than the cycle after accept.
- Extension by funct3:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: sign-extend word
  - 011 LD: full 64 bits
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - 110 LWU: zero-extend word
  - 111: data = 0, set wb_err
- Misalignment is checked upstream. wb_unit uses addr_lo as given; for LD only the shift is meaningful and addr_lo is expected to be 0.
- wb_pend = (state != IDLE) && held wen && held rd != 0. wb_pend_rd = held rd, or 0 when not pending. Both are asserted in the COMMIT cycle as well.
- wb_err is sticky until reset. It is set by:
  - dresp_valid in IDLE or COMMIT (the response is otherwise ignored);
  - funct3=111 on a load.
- Regfile interaction: rd=0 never produces wr_en=1. Regfile read-after-write in the same cycle is not bypassed here; forwarding uses wb_pend/data_rd.

Test Plan:
- Reset, then mem_valid with non-load rd=5, wen=1, result=0x1234, pc=0x80000000 → next cycle wr_en=1, index_rd=5, data_rd=0x1234, instr_valid=1, commit_pc=0x80000000; following cycle instr_valid=0.
- Load LB, addr_lo=3, dresp_data=0x00000000_80000000 arriving 4 cycles after accept → mem_ready=0 and wb_pend=1, wb_pend_rd=rd during the wait; commit data_rd=0xFFFFFFFF_FFFFFF80. Repeat with LBU → 0x80. LWU, addr_lo=4, dresp=0xDEADBEEF_00000000 → 0xDEADBEEF.
- Three back-to-back non-loads (rd=1,2,3) with mem_valid held high → three consecutive commit cycles, mem_ready=1 throughout.
- Non-load with rd=0, wen=1 → instr_valid=1, wr_en=0, wb_pend=0.
- Drive rstn low while in LOAD, release, then pulse dresp_valid → no commit, wb_err=1, state IDLE.
- Load with funct3=111 followed by dresp_valid → commit with data_rd=0, wb_err=1.
